// File: rtl/mem_access_stage.sv
// RV32I memory stage: runs one load/store at a time on the req/gnt/rvalid data bus,
// steers byte lanes, extends load data and emits a single registered writeback pulse.
module mem_access_stage #(
  parameter int RD_W = 5,
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [3:0]      mem_op,
  input  logic [RD_W-1:0] rd_in,
  input  logic            reg_write_in,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_we,
  output logic            misaligned
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic            is_byte_in, is_half_in, is_word_in, is_store_in, is_mem_in, mis_in;
  logic [3:0]      be_in;
  logic [XLEN-1:0] wdata_in;

  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      be_q, op_q;
  logic            we_q;
  logic [RD_W-1:0] rd_q;

  logic            take_mem, pulse_imm, pulse_store, pulse_load;
  logic [XLEN-1:0] rdata_shifted, load_val;

  // Input decode; opcodes 9-15 decode to no size and therefore behave as NONE.
  always_comb begin
    is_byte_in  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
    is_half_in  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    is_word_in  = (mem_op == OP_LW) || (mem_op == OP_SW);
    is_store_in = (mem_op == OP_SB) || (mem_op == OP_SH) || (mem_op == OP_SW);
    is_mem_in   = is_byte_in || is_half_in || is_word_in;
    mis_in      = (is_half_in && alu_result[0]) || (is_word_in && (alu_result[1:0] != 2'b00));

    be_in    = 4'b0000;
    wdata_in = store_data;
    if (is_byte_in) begin
      be_in    = 4'b0001 << alu_result[1:0];
      wdata_in = {4{store_data[7:0]}};
    end else if (is_half_in) begin
      be_in    = alu_result[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{store_data[15:0]}};
    end else if (is_word_in) begin
      be_in    = 4'b1111;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    dmem_req    = 1'b0;
    take_mem    = 1'b0;
    pulse_imm   = 1'b0;
    pulse_store = 1'b0;
    pulse_load  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          if (is_mem_in && !mis_in) begin
            take_mem = 1'b1;
            state_d  = REQ;
          end else begin
            pulse_imm = 1'b1;
          end
        end
      end
      REQ: begin
        // Request stays visible during a flush so a coincident grant is still honoured.
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          if (we_q) begin
            state_d     = IDLE;
            pulse_store = !flush;
          end else begin
            state_d = flush ? DRAIN : WAIT_R;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          state_d    = IDLE;
          pulse_load = !flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else if (take_mem) begin
      addr_q  <= {alu_result[XLEN-1:2], 2'b00};
      wdata_q <= wdata_in;
      be_q    <= be_in;
      op_q    <= mem_op;
      we_q    <= is_store_in;
      rd_q    <= rd_in;
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign dmem_we    = we_q;

  // addr_q keeps only the word address, so the lane is recovered from the byte enables.
  logic [1:0] lane;
  always_comb begin
    lane = 2'd0;
    case (be_q)
      4'b0010: lane = 2'd1;
      4'b0100: lane = 2'd2;
      4'b1000: lane = 2'd3;
      4'b1100: lane = 2'd2;
      default: lane = 2'd0;
    endcase
    rdata_shifted = dmem_rdata >> {lane, 3'b000};
    case (op_q)
      OP_LB:   load_val = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      OP_LBU:  load_val = {24'd0, rdata_shifted[7:0]};
      OP_LH:   load_val = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      OP_LHU:  load_val = {16'd0, rdata_shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;
      if (pulse_imm) begin
        // A faulting access reports its address in wb_data.
        wb_valid   <= 1'b1;
        wb_data    <= alu_result;
        wb_rd      <= rd_in;
        misaligned <= mis_in;
        wb_we      <= !mis_in && reg_write_in && (rd_in != '0);
      end else if (pulse_store) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
      end else if (pulse_load) begin
        wb_valid <= 1'b1;
        wb_data  <= load_val;
        wb_rd    <= rd_q;
        wb_we    <= (rd_q != '0);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single transactions plus
// hand sequences for flush and mid-transaction reset.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, store_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_in;
  logic        reg_write_in, flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we, misaligned;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.RD_W(5), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_op(mem_op),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        mem;
    logic        st;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wbd;
    logic        wbwe;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  initial begin
    //           op     addr          sdata         rd    rw  gd rv rdata         mem st  be       wdata         wbd           we  mis
    vecs[0]  = '{4'd0,  32'h0000_1234, 32'h0,        5'd5, 1, 0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h0000_1234, 1, 0};
    vecs[1]  = '{4'd6,  32'h0000_0103, 32'h0000_00AB, 5'd1, 0, 2, 1, 32'h0,        1,  1, 4'b1000, 32'hABAB_ABAB, 32'h0,        0, 0};
    vecs[2]  = '{4'd1,  32'h0000_0102, 32'h0,        5'd7, 1, 0, 2, 32'h0080_0000, 1,  0, 4'b0100, 32'h0,        32'hFFFF_FF80, 1, 0};
    vecs[3]  = '{4'd4,  32'h0000_0102, 32'h0,        5'd7, 1, 0, 2, 32'h0080_0000, 1,  0, 4'b0100, 32'h0,        32'h0000_0080, 1, 0};
    vecs[4]  = '{4'd5,  32'h0000_0102, 32'h0,        5'd8, 1, 1, 1, 32'hBEEF_0000, 1,  0, 4'b1100, 32'h0,        32'h0000_BEEF, 1, 0};
    vecs[5]  = '{4'd3,  32'h0000_0101, 32'h0,        5'd9, 1, 0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        0, 1};
    vecs[6]  = '{4'd3,  32'h0000_0100, 32'h0,        5'd0, 1, 0, 1, 32'h1234_5678, 1,  0, 4'b1111, 32'h0,        32'h1234_5678, 0, 0};
    vecs[7]  = '{4'd7,  32'h0000_0102, 32'h1234_CAFE, 5'd2, 0, 1, 1, 32'h0,        1,  1, 4'b1100, 32'hCAFE_CAFE, 32'h0,        0, 0};
    vecs[8]  = '{4'd8,  32'h0000_0200, 32'hDEAD_BEEF, 5'd3, 0, 0, 1, 32'h0,        1,  1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 0};
    vecs[9]  = '{4'd2,  32'h0000_0100, 32'h0,        5'd10,1, 0, 1, 32'h0001_8001, 1,  0, 4'b0011, 32'h0,        32'hFFFF_8001, 1, 0};
    vecs[10] = '{4'd7,  32'h0000_0105, 32'h0,        5'd4, 0, 0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        0, 1};
    vecs[11] = '{4'd0,  32'h0000_0777, 32'h0,        5'd3, 0, 0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h0000_0777, 0, 0};
    vecs[12] = '{4'd12, 32'h0000_0055, 32'h0,        5'd9, 1, 0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h0000_0055, 1, 0};
    vecs[13] = '{4'd1,  32'h0000_0101, 32'h0,        5'd11,1, 0, 3, 32'h0000_7F00, 1,  0, 4'b0010, 32'h0,        32'h0000_007F, 1, 0};

    reset = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; mem_op = '0;
    rd_in = '0; reg_write_in = 1'b0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    #4 reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; mem_op = vecs[i].op; alu_result = vecs[i].addr;
      store_data = vecs[i].sdata; rd_in = vecs[i].rd; reg_write_in = vecs[i].rw;
      tick();
      in_valid = 1'b0; mem_op = '0;
      if (vecs[i].mem) begin
        chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'd1);
        chk($sformatf("v%0d_addr", i), dmem_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].be));
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].st));
        if (vecs[i].st) chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
        for (int g = 0; g < vecs[i].gnt_dly; g++) begin
          tick();
          chk($sformatf("v%0d_req_hold", i), 32'(dmem_req), 32'd1);
          chk($sformatf("v%0d_be_hold", i), 32'(dmem_be), 32'(vecs[i].be));
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        if (!vecs[i].st) begin
          chk($sformatf("v%0d_wait_nowb", i), 32'(wb_valid), 32'd0);
          chk($sformatf("v%0d_wait_ready", i), 32'(in_ready), 32'd0);
          for (int r = 1; r < vecs[i].rv_dly; r++) tick();
          dmem_rdata = vecs[i].rdata; dmem_rvalid = 1'b1;
          tick();
          dmem_rvalid = 1'b0; dmem_rdata = '0;
        end
      end else begin
        chk($sformatf("v%0d_noreq", i), 32'(dmem_req), 32'd0);
      end
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_wb_we", i), 32'(wb_we), 32'(vecs[i].wbwe));
      chk($sformatf("v%0d_mis", i), 32'(misaligned), 32'(vecs[i].mis));
      if (!vecs[i].st && !vecs[i].mis) begin
        chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wbd);
        chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
      end
      tick();
      chk($sformatf("v%0d_pulse_end", i), 32'(wb_valid), 32'd0);
      chk($sformatf("v%0d_mis_end", i), 32'(misaligned), 32'd0);
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
    end

    // flush in IDLE drops the instruction
    in_valid = 1'b1; mem_op = 4'd0; alu_result = 32'h99; rd_in = 5'd6; reg_write_in = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_nowb", 32'(wb_valid), 32'd0);
    chk("fl_idle_noreq", 32'(dmem_req), 32'd0);

    // flush during WAIT_R, rvalid three cycles later
    in_valid = 1'b1; mem_op = 4'd3; alu_result = 32'h100; rd_in = 5'd4;
    tick();
    in_valid = 1'b0; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_wr_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("fl_wr_ready1", 32'(in_ready), 32'd0);
    tick();
    chk("fl_wr_ready2", 32'(in_ready), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("fl_wr_nowb", 32'(wb_valid), 32'd0);
    chk("fl_wr_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("fl_wr_nowb2", 32'(wb_valid), 32'd0);

    // flush in REQ before gnt
    in_valid = 1'b1; mem_op = 4'd8; alu_result = 32'h300; store_data = 32'h1111_2222;
    tick();
    in_valid = 1'b0;
    chk("fl_req_req", 32'(dmem_req), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_drop", 32'(dmem_req), 32'd0);
    chk("fl_req_ready", 32'(in_ready), 32'd1);
    chk("fl_req_nowb", 32'(wb_valid), 32'd0);
    tick();
    chk("fl_req_nowb2", 32'(wb_valid), 32'd0);

    // flush coincident with gnt: store commits silently, load drains
    in_valid = 1'b1; mem_op = 4'd6; alu_result = 32'h301; store_data = 32'h5A;
    tick();
    in_valid = 1'b0; dmem_gnt = 1'b1; flush = 1'b1;
    tick();
    dmem_gnt = 1'b0; flush = 1'b0;
    chk("fl_gnt_st_nowb", 32'(wb_valid), 32'd0);
    chk("fl_gnt_st_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; mem_op = 4'd1; alu_result = 32'h300; rd_in = 5'd12;
    tick();
    in_valid = 1'b0; dmem_gnt = 1'b1; flush = 1'b1;
    tick();
    dmem_gnt = 1'b0; flush = 1'b0;
    chk("fl_gnt_ld_drain", 32'(in_ready), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0042;
    tick();
    dmem_rvalid = 1'b0;
    chk("fl_gnt_ld_nowb", 32'(wb_valid), 32'd0);
    chk("fl_gnt_ld_ready", 32'(in_ready), 32'd1);

    // asynchronous reset while in REQ, then a stray rvalid
    in_valid = 1'b1; mem_op = 4'd6; alu_result = 32'h400; store_data = 32'h77;
    tick();
    in_valid = 1'b0;
    chk("rstm_req_before", 32'(dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstm_req_async", 32'(dmem_req), 32'd0);
    chk("rstm_ready_async", 32'(in_ready), 32'd1);
    #2 reset = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    chk("rstm_stray_nowb", 32'(wb_valid), 32'd0);
    chk("rstm_stray_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rstm_stray_nowb2", 32'(wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the RV32I pipeline, directly downstream of the execute ALU.
- Takes the registered ALU result (effective address or pass-through value), store data and decoded memory op.
- Runs load/store transactions on the data-memory request/grant/rvalid interface and handles byte/halfword lane steering and load sign/zero extension.
- Presents one registered writeback result per instruction; stalls upstream while a transaction is outstanding.

Parameters:
- RD_W, 5, destination register index width
- XLEN, 32, data/address width (only 32 supported)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept (high only in IDLE)
- alu_result  in  32  ALU data_out: address for mem ops, value otherwise
- store_data  in  32  rs2 value for stores
- mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- rd_in  in  RD_W  destination register
- reg_write_in  in  1  instruction writes rd
- flush  in  1  kill current/incoming instruction
- dmem_req  out  1  memory request
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  32  word-aligned address {alu_result[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- wb_valid  out  1  one-cycle result pulse
- wb_data  out  32  writeback value
- wb_rd  out  RD_W  writeback register
- wb_we  out  1  write rd (0 for stores, misaligned, rd=0)
- misaligned  out  1  pulsed with wb_valid on alignment fault

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except in_ready=1.
- States: IDLE, REQ, WAIT_R, DRAIN.
- IDLE, in_valid & ~flush:
  - NONE: next cycle wb_valid=1, wb_data=alu_result, wb_we=reg_write_in & (rd_in!=0). Latency 1, stays IDLE.
  - Misaligned (LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0): no dmem_req; next cycle wb_valid=1, misaligned=1, wb_we=0.
  - Aligned mem op: latch address/data/op/rd, go to REQ.
- REQ: dmem_req=1; dmem_addr, dmem_be, dmem_wdata, dmem_we stable until dmem_gnt.
  - On gnt, store: next cycle wb_valid=1, wb_we=0, go IDLE.
  - On gnt, load: go WAIT_R.
- WAIT_R: on dmem_rvalid, extract lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. Next cycle wb_valid=1, wb_data=result, wb_we=(rd!=0); go IDLE.
- dmem_rvalid in the same cycle as gnt is not allowed; rvalid arrives at least 1 cycle after gnt.
- Byte enables:
  - SB/LB/LBU: 1<<addr[1:0]
  - SH/LH/LHU: 4'b0011 or 4'b1100
  - word ops: 4'b1111
- dmem_wdata: byte replicated x4, half replicated x2, word unchanged.
- in_ready=1 only in IDLE. Upstream holds inputs while in_ready=0.
- Best-case throughput: store 2 cycles, load 3 cycles.
- flush:
  - In IDLE: incoming instruction dropped, no wb_valid.
  - In REQ before gnt: request dropped same cycle, go IDLE, no wb_valid.
  - In REQ coincident with gnt: store is committed to memory but wb_valid is suppressed; load goes to DRAIN.
  - In WAIT_R: go DRAIN.
  - DRAIN waits for dmem_rvalid, discards data, returns to IDLE; in_ready=0 throughout.
- wb_* outputs hold their last values when wb_valid=0; wb_valid, wb_we and misaligned are 0 except in the pulse cycle.
- Reset asserted mid-transaction returns to IDLE immediately; any later dmem_rvalid is ignored.

Test Plan:
- Reset low, then high; NONE op, alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, wb_we=1.
- SB addr=0x103, store_data=0xAB, gnt after 2 cycles -> dmem_addr=0x100, be=4'b1000, wdata=0xABABABAB held 3 cycles, then wb_valid with wb_we=0.
- LB addr=0x102, rdata=0x0080_0000, rvalid 2 cycles after gnt -> wb_data=0xFFFF_FF80; same with LBU -> 0x0000_0080; LHU addr=0x102, rdata=0xBEEF_0000 -> 0x0000_BEEF.
- LW addr=0x101 -> no dmem_req, wb_valid=1, misaligned=1, wb_we=0; LW with rd=0 -> wb_we=0.
- Flush during WAIT_R, rvalid 3 cycles later -> no wb_valid, in_ready=0 until the cycle after rvalid; flush in REQ before gnt -> dmem_req drops the same cycle.
- Reset pulled low while in REQ -> dmem_req=0 and in_ready=1 asynchronously; a stray rvalid after release produces no wb_valid.
